// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer FSM states plus address decode and
// protection helpers used by the completer and its checker.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  localparam int REGION_COUNT = 2;
  localparam int MAX_REGIONS  = 16;
  localparam int PROT_VEC_W   = MAX_REGIONS * 3;

  // Region number sits in the top rb bits of an addrWidth-bit address.
  function automatic int getRegion(input logic [31:0] addr, input int addrWidth, input int rb);
    if (rb == 0) return 0;
    return int'((addr >> (addrWidth - rb)) & ((32'd1 << rb) - 32'd1));
  endfunction

  function automatic logic validAlign(input logic [31:0] addr, input int alignBits);
    return (addr & ((32'd1 << alignBits) - 32'd1)) == 32'd0;
  endfunction

  function automatic logic protOk(input logic [2:0] pprot, input logic [31:0] addr,
                                  input int addrWidth, input int rb,
                                  input logic [PROT_VEC_W-1:0] regionProt);
    return pprot == regionProt[getRegion(addr, addrWidth, rb)*3 +: 3];
  endfunction

endpackage

// File: rtl/apb_prot_check.sv
// Combinational access check: flags misaligned, wrongly protected or
// out-of-range addresses and produces the memory word index.
module apb_prot_check
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH = 256,
  parameter int NUM_REGIONS = REGION_COUNT,
  parameter logic [NUM_REGIONS*3-1:0] REGION_PROT = {3'b111, 3'b000}
) (
  input  logic [ADDR_WIDTH-1:0]        paddr_i,
  input  logic [2:0]                   pprot_i,
  output logic                         err_o,
  output logic [$clog2(MEM_DEPTH)-1:0] index_o
);

  localparam int ALIGNBITS = $clog2(DATA_WIDTH / 8);
  localparam int RB = $clog2(NUM_REGIONS);
  localparam int IW = ADDR_WIDTH - RB - ALIGNBITS;
  localparam int MW = $clog2(MEM_DEPTH);

  logic [IW-1:0] wordIdx;
  logic [31:0]   addr32;

  // Region bits are dropped from the index so all regions alias one memory.
  assign wordIdx = paddr_i[ADDR_WIDTH-RB-1:ALIGNBITS];
  assign addr32  = 32'(paddr_i);
  assign index_o = wordIdx[MW-1:0];

  assign err_o = !validAlign(addr32, ALIGNBITS)
              || !protOk(pprot_i, addr32, ADDR_WIDTH, RB, PROT_VEC_W'(REGION_PROT))
              || (32'(wordIdx) >= 32'(MEM_DEPTH));

endmodule

// File: rtl/apb_prot_completer.sv
// APB4 completer with byte-strobed register memory, per-region PPROT
// checking, programmable wait states and a saturating error counter.
module apb_prot_completer
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH = 256,
  parameter int NUM_REGIONS = REGION_COUNT,
  parameter logic [NUM_REGIONS*3-1:0] REGION_PROT = {3'b111, 3'b000},
  parameter int WAIT_CYCLES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [2:0]              PPROT,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [7:0]              ERR_CNT
);

  localparam int MW = $clog2(MEM_DEPTH);
  localparam int SW = DATA_WIDTH / 8;

  apb_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [MW-1:0] index_q;
  logic write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0] strb_q;
  logic err_q;
  logic [7:0] errCnt_q;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic chkErr;
  logic [MW-1:0] chkIndex;
  logic complete;

  apb_prot_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .NUM_REGIONS(NUM_REGIONS),
    .REGION_PROT(REGION_PROT)
  ) u_check (
    .paddr_i(PADDR),
    .pprot_i(PPROT),
    .err_o  (chkErr),
    .index_o(chkIndex)
  );

  assign complete = (state_q == ACCESS) && (cnt_q == 4'd0) && PSEL && PENABLE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) state_d = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = 4'(WAIT_CYCLES);
      end
      ACCESS: begin
        // Dropping PSEL mid-access is a requester abort: nothing commits.
        if (!PSEL) state_d = IDLE;
        else if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else if (PENABLE) state_d = IDLE;
        else state_d = SETUP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      index_q  <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      err_q    <= 1'b0;
      errCnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == SETUP) begin
        index_q <= chkIndex;
        write_q <= PWRITE;
        wdata_q <= PWDATA;
        strb_q  <= PSTRB;
        err_q   <= chkErr;
      end
      if (complete && err_q && errCnt_q != 8'hFF) errCnt_q <= errCnt_q + 8'd1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (complete && write_q && !err_q) begin
      for (int b = 0; b < SW; b++) begin
        if (strb_q[b]) mem_q[index_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign PREADY  = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign PSLVERR = PREADY && err_q;
  assign PRDATA  = (PREADY && !write_q && !err_q) ? mem_q[index_q] : '0;
  assign ERR_CNT = errCnt_q;

endmodule

// File: tb/tb_apb_prot_completer.sv
// Directed bench for apb_prot_completer: one zero-wait instance and one
// three-wait instance driven by a simple APB requester task.
module tb_apb_prot_completer;

  logic        clock = 1'b0;
  logic        reset;
  logic        psel0, psel1, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;

  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1, pslverr0, pslverr1;
  logic [7:0]  errCnt0, errCnt1;

  logic        selDut;
  logic        curReady, curErr;
  logic [31:0] curRdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  apb_prot_completer #(.WAIT_CYCLES(0)) dut0 (
    .PCLK(clock), .PRESET(reset), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0), .ERR_CNT(errCnt0)
  );

  apb_prot_completer #(.WAIT_CYCLES(3)) dut1 (
    .PCLK(clock), .PRESET(reset), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1), .ERR_CNT(errCnt1)
  );

  assign curReady = selDut ? pready1 : pready0;
  assign curErr   = selDut ? pslverr1 : pslverr0;
  assign curRdata = selDut ? prdata1 : prdata0;

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full APB transfer; returns at the negedge where PREADY was seen high,
  // so a following call starts the next setup phase back-to-back.
  task automatic applyStimulus(input bit which, input logic wr, input logic [15:0] addr,
                               input logic [31:0] data, input logic [3:0] strb,
                               input logic [2:0] prot, output logic [31:0] rdata,
                               output logic err, output int cycles);
    bit done;
    @(negedge clock);
    selDut  = which;
    psel0   = !which;
    psel1   = which;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    pstrb   = strb;
    pprot   = prot;
    @(negedge clock);
    penable = 1'b1;
    cycles  = 0;
    rdata   = '0;
    err     = 1'b0;
    done    = 1'b0;
    while (!done) begin
      cycles++;
      if (curReady) begin
        rdata = curRdata;
        err   = curErr;
        done  = 1'b1;
      end else if (cycles >= 40) begin
        checkOutput("timeout", 32'(cycles), 32'd0);
        done = 1'b1;
      end else begin
        @(negedge clock);
      end
    end
  endtask

  task automatic busIdle();
    @(negedge clock);
    psel0   = 1'b0;
    psel1   = 1'b0;
    penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          cyc;
  int          errSeen;

  initial begin
    reset = 1'b1;
    selDut = 1'b0;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checkOutput("rst_pready", 32'(pready0), 32'd0);
    checkOutput("rst_pslverr", 32'(pslverr0), 32'd0);
    checkOutput("rst_prdata", prdata0, 32'd0);
    checkOutput("rst_errcnt", 32'(errCnt0), 32'd0);

    // PENABLE with PSEL while idle is a protocol violation and must be ignored
    psel0 = 1'b1; penable = 1'b1; paddr = 16'h0010; pprot = 3'b000; pwrite = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("idle_penable_ignored", 32'(pready0), 32'd0);
    psel0 = 1'b0; penable = 1'b0;

    applyStimulus(0, 1, 16'h0010, 32'hDEADBEEF, 4'hF, 3'b000, rd, er, cyc);
    checkOutput("t1_wr_cycles", 32'(cyc), 32'd2);
    checkOutput("t1_wr_err", 32'(er), 32'd0);
    applyStimulus(0, 0, 16'h0010, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    checkOutput("t1_rd_cycles", 32'(cyc), 32'd2);
    checkOutput("t1_rd_data", rd, 32'hDEADBEEF);
    checkOutput("t1_rd_err", 32'(er), 32'd0);

    applyStimulus(0, 1, 16'h0020, 32'h11223344, 4'hF, 3'b000, rd, er, cyc);
    applyStimulus(0, 1, 16'h0020, 32'hAABBCCDD, 4'b0101, 3'b000, rd, er, cyc);
    applyStimulus(0, 0, 16'h0020, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    checkOutput("t2_strobe_merge", rd, 32'h11BB33DD);

    applyStimulus(0, 0, 16'h8010, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    checkOutput("t3_badprot_err", 32'(er), 32'd1);
    checkOutput("t3_badprot_data", rd, 32'd0);
    busIdle();
    checkOutput("t3_errcnt", 32'(errCnt0), 32'd1);
    applyStimulus(0, 0, 16'h8010, 32'h0, 4'h0, 3'b111, rd, er, cyc);
    checkOutput("t3_goodprot_err", 32'(er), 32'd0);
    checkOutput("t3_goodprot_data", rd, 32'hDEADBEEF);

    // Region 1 aliases the same memory as region 0
    applyStimulus(0, 1, 16'h8020, 32'h00000055, 4'b0001, 3'b111, rd, er, cyc);
    applyStimulus(0, 0, 16'h0020, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    checkOutput("alias_region", rd, 32'h11BB3355);

    applyStimulus(0, 1, 16'h0013, 32'hFFFFFFFF, 4'hF, 3'b000, rd, er, cyc);
    checkOutput("t4_misalign_err", 32'(er), 32'd1);
    applyStimulus(0, 1, 16'h0400, 32'hFFFFFFFF, 4'hF, 3'b000, rd, er, cyc);
    checkOutput("t4_range_err", 32'(er), 32'd1);
    busIdle();
    checkOutput("t4_errcnt", 32'(errCnt0), 32'd3);
    applyStimulus(0, 0, 16'h0010, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    checkOutput("t4_word4_kept", rd, 32'hDEADBEEF);
    applyStimulus(0, 0, 16'h0000, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    checkOutput("t4_word0_kept", rd, 32'h0);

    errSeen = 0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(0, 0, 16'h8000, 32'h0, 4'h0, 3'b000, rd, er, cyc);
      if (er) errSeen++;
    end
    busIdle();
    checkOutput("t6_err_flags", 32'(errSeen), 32'd300);
    checkOutput("t6_errcnt_sat", 32'(errCnt0), 32'd255);

    applyStimulus(0, 1, 16'h0030, 32'hCAFEF00D, 4'hF, 3'b000, rd, er, cyc);
    applyStimulus(0, 0, 16'h0030, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    checkOutput("b2b_cycles", 32'(cyc), 32'd2);
    checkOutput("b2b_data", rd, 32'hCAFEF00D);
    busIdle();

    applyStimulus(1, 1, 16'h0040, 32'h12345678, 4'hF, 3'b000, rd, er, cyc);
    checkOutput("t5_wr_cycles", 32'(cyc), 32'd5);
    applyStimulus(1, 0, 16'h0040, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    checkOutput("t5_rd_cycles", 32'(cyc), 32'd5);
    checkOutput("t5_rd_data", rd, 32'h12345678);
    busIdle();

    // Start a waited write and hit reset during its second wait cycle
    @(negedge clock);
    selDut = 1'b1; psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 16'h0044; pwdata = 32'h99999999; pstrb = 4'hF; pprot = 3'b000;
    @(negedge clock);
    penable = 1'b1;
    @(negedge clock);
    checkOutput("t5_wait1_pready", 32'(pready1), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("t5_rst_pready", 32'(pready1), 32'd0);
    reset = 1'b0; psel1 = 1'b0; penable = 1'b0;
    applyStimulus(1, 0, 16'h0044, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    checkOutput("t5_aborted_word", rd, 32'h0);
    checkOutput("t5_post_rst_cycles", 32'(cyc), 32'd5);
    applyStimulus(1, 0, 16'h0040, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    checkOutput("t5_cleared_word", rd, 32'h0);
    busIdle();
    checkOutput("t5_dut0_errcnt_rst", 32'(errCnt0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
